// File: rtl/sr_seq_if.sv
// Word-level handshake between a producer and the shift-register sequencer.
//   start    producer -> ctrl  request; taken on a posedge with start && ready
//   data_in  producer -> ctrl  word to serialize; sampled only on acceptance
//   abort    producer -> ctrl  drop the word in flight
//   ready    ctrl -> producer  a start would be accepted this cycle
//   busy     ctrl -> producer  word in flight
//   q_out    ctrl -> producer  last captured parallel word
//   done     ctrl -> producer  one-cycle pulse when q_out updates
interface sr_seq_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             abort;
  logic             ready;
  logic             busy;
  logic [WIDTH-1:0] q_out;
  logic             done;

  modport master (
    output start, data_in, abort,
    input  ready, busy, q_out, done
  );

  modport slave (
    input  start, data_in, abort,
    output ready, busy, q_out, done
  );
endinterface

// File: rtl/sr_seq_ctrl.sv
// Sequencer for a serial-in/parallel-out shift register. Takes a word over the
// start/ready handshake, feeds it one bit per sr_en pulse (with GAP idle cycles
// between bits), then captures the register's parallel output into q_out and
// pulses done.
//   clk     clock, all state changes on posedge
//   rst_n   synchronous reset, active-low
//   bus     word handshake (sr_seq_if.slave): start/data_in/abort in,
//           ready/busy/q_out/done out
//   sr_in   serial data to the shift register
//   sr_en   shift enable; the register shifts on a posedge where sr_en=1
//   sr_q    parallel output of the shift register
module sr_seq_ctrl #(
  parameter int WIDTH     = 4,
  parameter int GAP       = 0,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  sr_seq_if.slave          bus,
  output logic             sr_in,
  output logic             sr_en,
  input  logic [WIDTH-1:0] sr_q
);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, CAPTURE} state_t;

  localparam int BW = $clog2(WIDTH + 1);
  // A GAP of 0 would give a zero-width counter; keep one bit that never moves.
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             sr_in_q, sr_in_d;
  logic             sr_en_q, sr_en_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [BW-1:0]    bit_next;

  // Bit n of the serial order; MSB_FIRST maps order 0 to the top bit.
  function automatic logic bit_of(input logic [WIDTH-1:0] w,
                                  input logic [BW-1:0]    n);
    logic [BW-1:0]    pos;
    logic [WIDTH-1:0] s;
    pos = MSB_FIRST ? (LAST_BIT - n) : n;
    s   = w >> pos;
    return s[0];
  endfunction

  assign bit_next = bit_q + BW'(1);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d  = state_q;
    shadow_d = shadow_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    sr_in_d  = sr_in_q;
    sr_en_d  = 1'b0;
    q_out_d  = q_out_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = SHIFT;
          shadow_d = bus.data_in;
          bit_d    = '0;
          gap_d    = '0;
          sr_in_d  = bit_of(bus.data_in, '0);
          sr_en_d  = 1'b1;
        end
      end

      SHIFT: begin
        if (bit_q == LAST_BIT) begin
          // Final bit shifts on this edge; sr_q is complete during CAPTURE.
          state_d = CAPTURE;
        end else if (GAP == 0) begin
          bit_d   = bit_next;
          sr_in_d = bit_of(shadow_q, bit_next);
          sr_en_d = 1'b1;
        end else begin
          // sr_in keeps the bit just shifted while the gap runs.
          state_d = HOLD;
          gap_d   = GAP_LOAD;
        end
      end

      HOLD: begin
        if (gap_q == '0) begin
          state_d = SHIFT;
          bit_d   = bit_next;
          sr_in_d = bit_of(shadow_q, bit_next);
          sr_en_d = 1'b1;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end

      CAPTURE: begin
        state_d = IDLE;
        q_out_d = sr_q;
        done_d  = 1'b1;
        sr_in_d = 1'b0;
        bit_d   = '0;
      end

      default: state_d = IDLE;
    endcase

    // Abort drops the word outright: nothing captured, q_out left alone.
    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
      sr_en_d = 1'b0;
      sr_in_d = 1'b0;
      done_d  = 1'b0;
      q_out_d = q_out_q;
      bit_d   = '0;
      gap_d   = '0;
    end

    // Status outputs are registered copies of where the FSM is going.
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: all state, including the shadow word, is cleared on reset so a
    // reset mid-word leaves nothing stale; the updates use <= so every
    // register samples the pre-edge values together.
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      sr_in_q  <= 1'b0;
      sr_en_q  <= 1'b0;
      q_out_q  <= '0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      sr_in_q  <= sr_in_d;
      sr_en_q  <= sr_en_d;
      q_out_q  <= q_out_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign sr_in     = sr_in_q;
  assign sr_en     = sr_en_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.q_out = q_out_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_sr_seq_ctrl.sv
// Directed bench for sr_seq_ctrl: instance a runs GAP=0, instance b GAP=2,
// each driving a behavioural shift register (shift left, sr_in into LSB).
module tb_sr_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sr_seq_if #(.WIDTH(4)) a_if ();
  sr_seq_if #(.WIDTH(4)) b_if ();

  logic       a_sr_in, a_sr_en, b_sr_in, b_sr_en;
  logic [3:0] a_sr_q, b_sr_q;

  sr_seq_ctrl #(.WIDTH(4), .GAP(0), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if.slave),
    .sr_in(a_sr_in), .sr_en(a_sr_en), .sr_q(a_sr_q)
  );

  sr_seq_ctrl #(.WIDTH(4), .GAP(2), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if.slave),
    .sr_in(b_sr_in), .sr_en(b_sr_en), .sr_q(b_sr_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr_q <= '0;
      b_sr_q <= '0;
    end else begin
      if (a_sr_en) a_sr_q <= {a_sr_q[2:0], a_sr_in};
      if (b_sr_en) b_sr_q <= {b_sr_q[2:0], b_sr_in};
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int pulses;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word to instance a for one edge; data_in is scrambled afterwards.
  task automatic accept_a(input logic [3:0] d, input logic ab);
    a_if.data_in = d;
    a_if.start   = 1'b1;
    a_if.abort   = ab;
    tick();
    a_if.start   = 1'b0;
    a_if.abort   = 1'b0;
    a_if.data_in = ~d;
    check("a_busy_on_accept", a_if.busy, 1);
    check("a_ready_on_accept", a_if.ready, 0);
  endtask

  // Follow an accepted word on instance a through to done.
  task automatic run_a(input logic [3:0] d, input bit chain, input logic [3:0] nd);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      check("a_sr_en_bit", a_sr_en, 1);
      check("a_sr_in_bit", a_sr_in, d[3-i]);
      check("a_done_low", a_if.done, 0);
      if (a_sr_en) pulses++;
      if (i == 1) begin
        a_if.start   = 1'b1;
        a_if.data_in = 4'h7;
      end
      if (i == 2) a_if.start = 1'b0;
      tick();
    end
    check("a_sr_en_capture", a_sr_en, 0);
    check("a_done_capture", a_if.done, 0);
    check("a_busy_capture", a_if.busy, 1);
    tick();
    check("a_done_pulse", a_if.done, 1);
    check("a_q_out", a_if.q_out, d);
    check("a_ready_done", a_if.ready, 1);
    check("a_busy_done", a_if.busy, 0);
    check("a_pulse_count", pulses, 4);
    if (chain) begin
      a_if.start   = 1'b1;
      a_if.data_in = nd;
      tick();
      a_if.start   = 1'b0;
      a_if.data_in = ~nd;
      check("a_chain_busy", a_if.busy, 1);
    end else begin
      tick();
    end
    check("a_done_one_cycle", a_if.done, 0);
  endtask

  logic [9:0] en_pat = 10'b1001001001;
  logic [9:0] in_pat = 10'b0001111110;

  initial begin
    rst_n = 1'b0;
    a_if.start = 1'b0; a_if.abort = 1'b0; a_if.data_in = '0;
    b_if.start = 1'b0; b_if.abort = 1'b0; b_if.data_in = '0;

    // Reset state
    tick();
    tick();
    check("rst_a_ready", a_if.ready, 1);
    check("rst_a_busy", a_if.busy, 0);
    check("rst_a_sr_en", a_sr_en, 0);
    check("rst_a_q_out", a_if.q_out, 4'h0);
    check("rst_a_done", a_if.done, 0);
    check("rst_b_ready", b_if.ready, 1);
    check("rst_b_sr_en", b_sr_en, 0);
    rst_n = 1'b1;
    tick();

    // Single word, GAP=0
    accept_a(4'b1011, 1'b0);
    run_a(4'b1011, 1'b0, 4'h0);

    // Back-to-back words, start in the done cycle
    accept_a(4'hA, 1'b0);
    run_a(4'hA, 1'b1, 4'h5);
    run_a(4'h5, 1'b0, 4'h0);

    // Abort after the second shift pulse
    accept_a(4'hF, 1'b0);
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      check("ab_sr_en", a_sr_en, 1);
      if (a_sr_en) pulses++;
      if (i == 1) a_if.abort = 1'b1;
      tick();
    end
    a_if.abort = 1'b0;
    check("ab_sr_en_off", a_sr_en, 0);
    check("ab_sr_in_zero", a_sr_in, 0);
    check("ab_busy", a_if.busy, 0);
    check("ab_ready", a_if.ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("ab_no_done", a_if.done, 0);
      check("ab_q_kept", a_if.q_out, 4'h5);
      if (a_sr_en) pulses++;
      tick();
    end
    check("ab_pulse_count", pulses, 2);

    // GAP=2 word on instance b
    b_if.data_in = 4'b0110;
    b_if.start   = 1'b1;
    tick();
    b_if.start   = 1'b0;
    b_if.data_in = 4'b1001;
    for (int i = 0; i < 10; i++) begin
      check("b_sr_en_pat", b_sr_en, en_pat[9-i]);
      check("b_sr_in_pat", b_sr_in, in_pat[9-i]);
      check("b_done_low", b_if.done, 0);
      tick();
    end
    check("b_sr_en_capture", b_sr_en, 0);
    tick();
    check("b_done_pulse", b_if.done, 1);
    check("b_q_out", b_if.q_out, 4'h6);
    tick();
    check("b_done_one_cycle", b_if.done, 0);

    // Reset during the third bit of 4'h9
    accept_a(4'h9, 1'b0);
    tick();
    tick();
    check("rs_third_bit_en", a_sr_en, 1);
    check("rs_third_bit_in", a_sr_in, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rs_sr_en", a_sr_en, 0);
    check("rs_q_out", a_if.q_out, 4'h0);
    check("rs_done", a_if.done, 0);
    check("rs_ready", a_if.ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("rs_no_done", a_if.done, 0);
      tick();
    end

    // Next word completes; abort together with start in IDLE is ignored
    accept_a(4'h3, 1'b1);
    run_a(4'h3, 1'b0, 4'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
